particle_field: RTL and testbench



---
 rtl/particle_field.sv | 187 ++++++++++++++++++
 tb/tb_particle_field.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/particle_field.sv
// Animated square particles in a bounding box, updated serially at each frame start,
// with a registered per-pixel hit test. Define PARTICLE_RESPAWN_EN for respawn instead of wrap.
module particle_field #(
  parameter int unsigned N_PART = 8,
  parameter int unsigned SIZE   = 10,
  parameter int unsigned BOX_X0 = 150,
  parameter int unsigned BOX_Y0 = 120,
  parameter int unsigned BOX_W  = 340,
  parameter int unsigned BOX_H  = 240,
  parameter int unsigned FC_W   = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [9:0]      pix_x,
  input  logic [9:0]      pix_y,
  input  logic            video_active,
  input  logic            vsync,
  output logic            hit,
  output logic [3:0]      hit_id,
  output logic            busy,
  output logic [FC_W-1:0] frame_cnt
);

  localparam int unsigned IDX_W = (N_PART > 1) ? $clog2(N_PART) : 1;
  localparam int unsigned XMAX  = BOX_X0 + BOX_W - SIZE;
  localparam int unsigned YMAX  = BOX_Y0 + BOX_H - SIZE;
  localparam int unsigned CX    = BOX_X0 + BOX_W / 2 - SIZE / 2;
  localparam int unsigned CY    = BOX_Y0 + BOX_H / 2 - SIZE / 2;

  typedef enum logic {IDLE, UPDATE} state_t;

  state_t            r_state, w_state_nxt;
  logic [IDX_W-1:0]  r_idx, w_idx_nxt;
  logic              r_vs_d;
  logic              w_vs_rise;
  logic              w_last;
  logic [9:0]        r_px [N_PART];
  logic [9:0]        r_py [N_PART];
  logic [2:0]        r_dx [N_PART];
  logic [2:0]        r_dy [N_PART];
  logic signed [10:0] w_nx, w_ny;
  logic [9:0]        w_px_new, w_py_new;
  logic [2:0]        w_dx_new, w_dy_new;
  logic              w_any;
  logic [3:0]        w_id;

  function automatic logic [2:0] init_dx(input int k);
    int v;
    v = (k % 7) - 3;
    if (v == 0) v = 1;
    return 3'(v);
  endfunction

  function automatic logic [2:0] init_dy(input int k);
    int v;
    v = ((k + 3) % 7) - 3;
    if (v == 0) v = -1;
    return 3'(v);
  endfunction

  assign w_vs_rise = vsync & ~r_vs_d;
  assign w_last    = (r_idx == IDX_W'(N_PART - 1));

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  // FSM next state; a vsync rise while updating is ignored
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    case (r_state)
      IDLE: begin
        if (w_vs_rise) begin
          w_state_nxt = UPDATE;
          w_idx_nxt   = '0;
        end
      end
      UPDATE: begin
        if (w_last) begin
          w_state_nxt = IDLE;
          w_idx_nxt   = '0;
        end else begin
          w_idx_nxt = r_idx + IDX_W'(1);
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vs_d    <= 1'b0;
      busy      <= 1'b0;
      frame_cnt <= '0;
    end else begin
      r_vs_d <= vsync;
      busy   <= (w_state_nxt == UPDATE);
      if (r_state == UPDATE && w_last) frame_cnt <= frame_cnt + FC_W'(1);
    end
  end

`ifdef PARTICLE_RESPAWN_EN
  logic [15:0] r_lfsr;

  function automatic logic [2:0] map_vel(input logic [2:0] v);
    if (v == 3'b000) return 3'b001;
    if (v == 3'b100) return 3'b101;
    return v;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_lfsr <= 16'hACE1;
    else if (r_state == UPDATE) r_lfsr <= (r_lfsr >> 1) ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
  end
`endif

  // Candidate position for the particle under update, then the boundary rule
  always_comb begin
    w_nx     = $signed({1'b0, r_px[r_idx]}) + 11'($signed(r_dx[r_idx]));
    w_ny     = $signed({1'b0, r_py[r_idx]}) + 11'($signed(r_dy[r_idx]));
    w_px_new = w_nx[9:0];
    w_py_new = w_ny[9:0];
    w_dx_new = r_dx[r_idx];
    w_dy_new = r_dy[r_idx];
`ifdef PARTICLE_RESPAWN_EN
    if (w_nx < $signed(11'(BOX_X0)) || w_nx > $signed(11'(XMAX)) ||
        w_ny < $signed(11'(BOX_Y0)) || w_ny > $signed(11'(YMAX))) begin
      w_px_new = 10'(CX);
      w_py_new = 10'(CY);
      w_dx_new = map_vel(r_lfsr[2:0]);
      w_dy_new = map_vel(r_lfsr[5:3]);
    end
`else
    if (w_nx < $signed(11'(BOX_X0)))      w_px_new = 10'(XMAX);
    else if (w_nx > $signed(11'(XMAX)))   w_px_new = 10'(BOX_X0);
    if (w_ny < $signed(11'(BOX_Y0)))      w_py_new = 10'(YMAX);
    else if (w_ny > $signed(11'(YMAX)))   w_py_new = 10'(BOX_Y0);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < int'(N_PART); k++) begin
        r_px[k] <= 10'(CX);
        r_py[k] <= 10'(CY);
        r_dx[k] <= init_dx(k);
        r_dy[k] <= init_dy(k);
      end
    end else if (r_state == UPDATE) begin
      r_px[r_idx] <= w_px_new;
      r_py[r_idx] <= w_py_new;
      r_dx[r_idx] <= w_dx_new;
      r_dy[r_idx] <= w_dy_new;
    end
  end

  // Hit test; modular differences make pixels left of / above a particle miss
  always_comb begin
    w_any = 1'b0;
    w_id  = 4'd0;
    for (int k = int'(N_PART) - 1; k >= 0; k--) begin
      if (((pix_x - r_px[k]) < 10'(SIZE)) && ((pix_y - r_py[k]) < 10'(SIZE))) begin
        w_any = 1'b1;
        w_id  = 4'(k);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit    <= 1'b0;
      hit_id <= 4'd0;
    end else begin
      hit    <= video_active & w_any;
      hit_id <= (video_active & w_any) ? w_id : 4'd0;
    end
  end

endmodule

// File: tb/tb_particle_field.sv
// Directed bench for particle_field with default parameters; covers wrap or respawn build.
module tb_particle_field;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] pix_x = '0;
  logic [9:0] pix_y = '0;
  logic       video_active = 1'b0;
  logic       vsync = 1'b0;
  logic       hit;
  logic [3:0] hit_id;
  logic       busy;
  logic [7:0] frame_cnt;

  int checks = 0;
  int errors = 0;

  particle_field dut (
    .clk(clk), .rst_n(rst_n), .pix_x(pix_x), .pix_y(pix_y),
    .video_active(video_active), .vsync(vsync),
    .hit(hit), .hit_id(hit_id), .busy(busy), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", name, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
  endtask

  // Pulse vsync and count busy cycles over a fixed window; optional re-trigger mid-update
  task automatic run_frame(input bit retrig, output int nbusy);
    nbusy = 0;
    @(negedge clk) vsync = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy) nbusy++;
      if (i == 0) vsync = 1'b0;
      if (retrig && i == 2) vsync = 1'b1;
      if (retrig && i == 4) vsync = 1'b0;
    end
  endtask

  task automatic probe(input string name, input int x, input int y, input bit va,
                       input logic exp_hit, input logic [3:0] exp_id);
    @(negedge clk);
    pix_x = 10'(x);
    pix_y = 10'(y);
    video_active = va;
    @(negedge clk);
    chk({name, "_hit"}, 32'(hit), 32'(exp_hit));
    chk({name, "_id"}, 32'(hit_id), 32'(exp_id));
  endtask

`ifdef PARTICLE_RESPAWN_EN
  function automatic logic [2:0] map_vel(input logic [2:0] v);
    case (v)
      3'b000:  return 3'b001;
      3'b100:  return 3'b101;
      default: return v;
    endcase
  endfunction
`endif

  initial begin
    int nb;
    logic [15:0] lfsr;

    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_fc", 32'(frame_cnt), 0);
    chk("rst_hit", 32'(hit), 0);
    rst_n = 1'b1;

    probe("centre", 315, 235, 1'b1, 1'b1, 4'd0);
    probe("corner", 324, 244, 1'b1, 1'b1, 4'd0);
    probe("right_edge", 325, 235, 1'b1, 1'b0, 4'd0);
    probe("above", 315, 234, 1'b1, 1'b0, 4'd0);

    run_frame(1'b0, nb);
    chk("f1_busy_len", 32'(nb), 8);
    chk("f1_fc", 32'(frame_cnt), 1);
    probe("p0", 312, 234, 1'b1, 1'b1, 4'd0);
    probe("p0_blank", 312, 234, 1'b0, 1'b0, 4'd0);
    probe("p4", 318, 232, 1'b1, 1'b1, 4'd4);
    probe("p6", 327, 243, 1'b1, 1'b1, 4'd6);

    run_frame(1'b1, nb);
    chk("retrig_busy_len", 32'(nb), 8);
    chk("retrig_fc", 32'(frame_cnt), 2);

    do_reset();
    for (int f = 0; f < 55; f++) run_frame(1'b0, nb);
    chk("f55_px", 32'(dut.r_px[0]), 150);
    chk("f55_py", 32'(dut.r_py[0]), 180);
    run_frame(1'b0, nb);
    chk("f56_fc", 32'(frame_cnt), 56);
`ifdef PARTICLE_RESPAWN_EN
    lfsr = 16'hACE1;
    for (int s = 0; s < 440; s++) lfsr = (lfsr >> 1) ^ (lfsr[0] ? 16'hB400 : 16'h0000);
    chk("f56_px", 32'(dut.r_px[0]), 315);
    chk("f56_py", 32'(dut.r_py[0]), 235);
    chk("f56_dx", 32'(dut.r_dx[0]), 32'(map_vel(lfsr[2:0])));
    chk("f56_dy", 32'(dut.r_dy[0]), 32'(map_vel(lfsr[5:3])));
`else
    lfsr = 16'h0;
    chk("f56_px", 32'(dut.r_px[0]), 480);
    chk("f56_py", 32'(dut.r_py[0]), 179);
    chk("f56_dx", 32'(dut.r_dx[0]), 32'(3'b101 ^ lfsr[2:0]));
`endif

    // Reset in the middle of an update, with the probe pixel on particle 0
    do_reset();
    @(negedge clk);
    pix_x = 10'd315;
    pix_y = 10'd235;
    video_active = 1'b1;
    @(negedge clk) vsync = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 0) vsync = 1'b0;
    end
    chk("mid_idx", 32'(dut.r_idx), 4);
    chk("mid_busy_pre", 32'(busy), 1);
    chk("mid_hit_pre", 32'(hit), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_busy", 32'(busy), 0);
    chk("mid_fc", 32'(frame_cnt), 0);
    chk("mid_hit", 32'(hit), 0);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("mid_px%0d", k), 32'(dut.r_px[k]), 315);
      chk($sformatf("mid_py%0d", k), 32'(dut.r_py[k]), 235);
    end
    @(negedge clk) rst_n = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
